// File: rtl/payment_controller.sv
// Payment stage: latches price/ID, accumulates coins, requests dispense, returns change or refunds.
// Optional inactivity auto-refund is compiled in when PAY_TIMEOUT_EN is defined.
module payment_controller #(
    parameter logic [4:0] VAL_C1      = 5'd5,
    parameter logic [4:0] VAL_C2      = 5'd10,
    parameter logic [4:0] VAL_C3      = 5'd20,
    parameter logic [5:0] CHANGE_UNIT = 6'd5
`ifdef PAY_TIMEOUT_EN
    ,
    parameter int                   TIMEOUT_W      = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'd50000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       price_load,
    input  logic [4:0] product_price,
    input  logic [1:0] product_id,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       cancel,
    input  logic       dispense_ack,
    output logic       busy,
    output logic [5:0] credit,
    output logic       coin_reject,
    output logic       dispense_valid,
    output logic [1:0] dispense_id,
    output logic       change_pulse,
    output logic       timeout_flag
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DISPENSE,
        ST_RETURN
    } state_t;

    state_t      state_reg, state_next;
    logic [5:0]  credit_reg, credit_next;
    logic [4:0]  price_reg, price_next;
    logic [1:0]  id_reg, id_next;
    logic [5:0]  amount_reg, amount_next;
    logic        coin_reject_reg, coin_reject_next;
    logic        timeout_flag_reg, timeout_flag_next;

    logic [5:0]  coin_value;
    logic        coin_accept;
    logic [5:0]  credit_sum;
    logic [5:0]  price_ext;
    logic        timeout_hit;

`ifdef PAY_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] CNT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_CYCLES - CNT_ONE;

    logic [TIMEOUT_W-1:0] counter_reg, counter_next;

    assign timeout_hit = (counter_reg == CNT_LAST) && !coin_accept;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        coin_value = 6'd0;
        case (coin_type)
            2'b01:   coin_value = {1'b0, VAL_C1};
            2'b10:   coin_value = {1'b0, VAL_C2};
            2'b11:   coin_value = {1'b0, VAL_C3};
            default: coin_value = 6'd0;
        endcase
    end

    // Only COLLECT accepts coins; anything else strobed in is handed back.
    assign coin_accept      = coin_valid && (coin_type != 2'b00) && (state_reg == ST_COLLECT);
    assign coin_reject_next = coin_valid && !coin_accept;
    assign credit_sum       = credit_reg + (coin_accept ? coin_value : 6'd0);
    assign price_ext        = {1'b0, price_reg};

    always_comb begin
        state_next        = state_reg;
        credit_next       = credit_reg;
        price_next        = price_reg;
        id_next           = id_reg;
        amount_next       = amount_reg;
        timeout_flag_next = 1'b0;
`ifdef PAY_TIMEOUT_EN
        counter_next      = counter_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (price_load && (product_price != 5'd0)) begin
                    price_next  = product_price;
                    id_next     = product_id;
                    credit_next = 6'd0;
                    state_next  = ST_COLLECT;
`ifdef PAY_TIMEOUT_EN
                    counter_next = '0;
`endif
                end
            end
            ST_COLLECT: begin
                credit_next = credit_sum;
`ifdef PAY_TIMEOUT_EN
                counter_next = coin_accept ? '0 : counter_reg + CNT_ONE;
`endif
                // Cancel wins over a covering credit; a same-cycle coin is refunded too.
                if (cancel) begin
                    amount_next = credit_sum;
                    credit_next = 6'd0;
                    state_next  = ST_RETURN;
                end else if (credit_reg >= price_ext) begin
                    state_next = ST_DISPENSE;
                end else if (timeout_hit) begin
                    timeout_flag_next = 1'b1;
                    amount_next       = credit_reg;
                    credit_next       = 6'd0;
                    state_next        = (credit_reg == 6'd0) ? ST_IDLE : ST_RETURN;
                end
            end
            ST_DISPENSE: begin
                if (dispense_ack) begin
                    amount_next = credit_reg - price_ext;
                    credit_next = 6'd0;
                    state_next  = ((credit_reg - price_ext) >= CHANGE_UNIT) ? ST_RETURN : ST_IDLE;
                end
            end
            ST_RETURN: begin
                if (amount_reg >= CHANGE_UNIT) begin
                    amount_next = amount_reg - CHANGE_UNIT;
                end else begin
                    // Sub-unit remainder cannot be paid out and is forfeited.
                    amount_next = 6'd0;
                    credit_next = 6'd0;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            credit_reg       <= 6'd0;
            price_reg        <= 5'd0;
            id_reg           <= 2'd0;
            amount_reg       <= 6'd0;
            coin_reject_reg  <= 1'b0;
            timeout_flag_reg <= 1'b0;
`ifdef PAY_TIMEOUT_EN
            counter_reg      <= '0;
`endif
        end else begin
            state_reg        <= state_next;
            credit_reg       <= credit_next;
            price_reg        <= price_next;
            id_reg           <= id_next;
            amount_reg       <= amount_next;
            coin_reject_reg  <= coin_reject_next;
            timeout_flag_reg <= timeout_flag_next;
`ifdef PAY_TIMEOUT_EN
            counter_reg      <= counter_next;
`endif
        end
    end

    // Outputs decode registered state only, so an async reset clears them at once.
    assign busy           = (state_reg != ST_IDLE);
    assign credit         = credit_reg;
    assign coin_reject    = coin_reject_reg;
    assign dispense_valid = (state_reg == ST_DISPENSE);
    assign dispense_id    = (state_reg == ST_DISPENSE) ? id_reg : 2'b00;
    assign change_pulse   = (state_reg == ST_RETURN) && (amount_reg >= CHANGE_UNIT);
    assign timeout_flag   = timeout_flag_reg;

endmodule
